// File: rtl/alu_commit_if.sv
// Bundles the ALU-result, status and register-file write signals of the commit stage.
// slave is the commit stage's view; master is the view of whatever drives the ALU and RF sides.
interface alu_commit_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] ALU_RESULT;
  logic          ALU_FLAG;
  logic          ALU_OVERFLOW;
  logic          FLAG_WRITE;
  logic          OVERFLOW_WRITE;
  logic          REG_WRITE;
  logic [AW-1:0] WR_ADDR;
  logic          FLAG_Q;
  logic          OVERFLOW_Q;
  logic          RF_VALID;
  logic          RF_READY;
  logic [AW-1:0] RF_ADDR;
  logic [DW-1:0] RF_DATA;
  logic [7:0]    COMMIT_COUNT;

  modport slave (
    input  IN_VALID, ALU_RESULT, ALU_FLAG, ALU_OVERFLOW, FLAG_WRITE,
           OVERFLOW_WRITE, REG_WRITE, WR_ADDR, RF_READY,
    output IN_READY, FLAG_Q, OVERFLOW_Q, RF_VALID, RF_ADDR, RF_DATA, COMMIT_COUNT
  );

  modport master (
    output IN_VALID, ALU_RESULT, ALU_FLAG, ALU_OVERFLOW, FLAG_WRITE,
           OVERFLOW_WRITE, REG_WRITE, WR_ADDR, RF_READY,
    input  IN_READY, FLAG_Q, OVERFLOW_Q, RF_VALID, RF_ADDR, RF_DATA, COMMIT_COUNT
  );
endinterface

// File: rtl/alu_commit.sv
// Commit stage behind the ALU: architectural FLAG/OVERFLOW registers, a commit counter,
// and a 2-entry FIFO that holds register-file writes while the shared write port stalls.
module alu_commit #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input logic         CLK,
  input logic         RESET_N,
  alu_commit_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } queueState_e;

  queueState_e   state_q;
  logic [AW-1:0] headAddr_q;
  logic [DW-1:0] headData_q;
  logic [AW-1:0] tailAddr_q;
  logic [DW-1:0] tailData_q;
  logic          flag_q;
  logic          overflow_q;
  logic [7:0]    commitCount_q;
  logic [7:0]    commitCount_d;

  logic accept;
  logic push;
  logic pop;

  // Ready is a pure decode of the queue state, so RF backpressure never reaches the ALU combinationally.
  assign bus.IN_READY = (state_q != FULL);
  assign bus.RF_VALID = (state_q != EMPTY);
  assign bus.RF_ADDR  = headAddr_q;
  assign bus.RF_DATA  = headData_q;
  assign bus.FLAG_Q       = flag_q;
  assign bus.OVERFLOW_Q   = overflow_q;
  assign bus.COMMIT_COUNT = commitCount_q;

  assign accept = bus.IN_VALID && bus.IN_READY;
  assign push   = accept && bus.REG_WRITE;
  assign pop    = bus.RF_VALID && bus.RF_READY;

  assign commitCount_d = commitCount_q + 8'd1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= EMPTY;
      headAddr_q    <= '0;
      headData_q    <= '0;
      tailAddr_q    <= '0;
      tailData_q    <= '0;
      flag_q        <= 1'b0;
      overflow_q    <= 1'b0;
      commitCount_q <= 8'd0;
    end else begin
      // Status is committed at accept time so the very next ALU op sees it, even if the RF is stalled.
      if (accept) begin
        commitCount_q <= commitCount_d;
        if (bus.FLAG_WRITE) begin
          flag_q <= bus.ALU_FLAG;
        end
        if (bus.OVERFLOW_WRITE) begin
          overflow_q <= bus.ALU_OVERFLOW;
        end
      end

      case (state_q)
        EMPTY: begin
          if (push) begin
            headAddr_q <= bus.WR_ADDR;
            headData_q <= bus.ALU_RESULT;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            headAddr_q <= bus.WR_ADDR;
            headData_q <= bus.ALU_RESULT;
          end else if (push) begin
            tailAddr_q <= bus.WR_ADDR;
            tailData_q <= bus.ALU_RESULT;
            state_q    <= FULL;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          // No push can arrive here because IN_READY is low.
          if (pop) begin
            headAddr_q <= tailAddr_q;
            headData_q <= tailData_q;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_commit.sv
// Directed bench for alu_commit: a table of per-cycle vectors with hand-computed results,
// plus hand-written sequences for asynchronous reset, sustained push+pop and counter wrap.
module tb_alu_commit;

  localparam int DW = 8;
  localparam int AW = 4;

  logic CLK;
  logic RESET_N;

  int checkCount;
  int passCount;

  alu_commit_if #(.DW(DW), .AW(AW)) bus ();

  alu_commit #(.DW(DW), .AW(AW)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       inValid;
    logic       regWrite;
    logic       flagWrite;
    logic       ovfWrite;
    logic       aluFlag;
    logic       aluOvf;
    logic [3:0] wrAddr;
    logic [7:0] aluResult;
    logic       rfReady;
    logic       expInReady;
    logic       expRfValid;
    logic [3:0] expRfAddr;
    logic [7:0] expRfData;
    logic       expFlag;
    logic       expOvf;
    logic [7:0] expCount;
  } vector_t;

  vector_t vec [16];

  // Every comparison in the bench funnels through here so the counters stay consistent.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic driveInputs(input logic iv, input logic rw, input logic fw, input logic ow,
                             input logic af, input logic ao, input logic [3:0] addr,
                             input logic [7:0] res, input logic rr);
    bus.IN_VALID       = iv;
    bus.REG_WRITE      = rw;
    bus.FLAG_WRITE     = fw;
    bus.OVERFLOW_WRITE = ow;
    bus.ALU_FLAG       = af;
    bus.ALU_OVERFLOW   = ao;
    bus.WR_ADDR        = addr;
    bus.ALU_RESULT     = res;
    bus.RF_READY       = rr;
  endtask

  // Drives one vector, checks IN_READY just before the edge, then checks all outputs after it.
  task automatic applyStimulus(input int idx, input logic prevInReady);
    vector_t v;
    v = vec[idx];
    driveInputs(v.inValid, v.regWrite, v.flagWrite, v.ovfWrite, v.aluFlag, v.aluOvf,
                v.wrAddr, v.aluResult, v.rfReady);
    #1;
    checkOutput($sformatf("vec%0d IN_READY pre-edge", idx), {7'd0, bus.IN_READY}, {7'd0, prevInReady});
    @(posedge CLK);
    #1;
    checkOutput($sformatf("vec%0d IN_READY", idx), {7'd0, bus.IN_READY}, {7'd0, v.expInReady});
    checkOutput($sformatf("vec%0d RF_VALID", idx), {7'd0, bus.RF_VALID}, {7'd0, v.expRfValid});
    if (v.expRfValid) begin
      checkOutput($sformatf("vec%0d RF_ADDR", idx), {4'd0, bus.RF_ADDR}, {4'd0, v.expRfAddr});
      checkOutput($sformatf("vec%0d RF_DATA", idx), bus.RF_DATA, v.expRfData);
    end
    checkOutput($sformatf("vec%0d FLAG_Q", idx), {7'd0, bus.FLAG_Q}, {7'd0, v.expFlag});
    checkOutput($sformatf("vec%0d OVERFLOW_Q", idx), {7'd0, bus.OVERFLOW_Q}, {7'd0, v.expOvf});
    checkOutput($sformatf("vec%0d COMMIT_COUNT", idx), bus.COMMIT_COUNT, v.expCount);
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RESET_N = 1'b0;
    driveInputs(0, 0, 0, 0, 0, 0, 4'd0, 8'd0, 0);
    stepCycle();
    stepCycle();
    RESET_N = 1'b1;
  endtask

  initial begin
    logic [7:0] prevData;
    logic       prevReady;

    checkCount = 0;
    passCount  = 0;

    //           iv rw fw ow af ao addr  res    rr   eir erv ea    ed     ef eo ec
    vec[0]  = '{1, 1, 0, 0, 0, 0, 4'd1, 8'h11, 1,   1,  1,  4'd1, 8'h11, 0, 0, 8'd1};
    vec[1]  = '{1, 1, 0, 0, 0, 0, 4'd2, 8'h22, 1,   1,  1,  4'd2, 8'h22, 0, 0, 8'd2};
    vec[2]  = '{1, 1, 0, 0, 0, 0, 4'd3, 8'h33, 1,   1,  1,  4'd3, 8'h33, 0, 0, 8'd3};
    vec[3]  = '{0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 1,   1,  0,  4'd0, 8'h00, 0, 0, 8'd3};
    vec[4]  = '{1, 1, 0, 0, 0, 0, 4'd4, 8'hA0, 0,   1,  1,  4'd4, 8'hA0, 0, 0, 8'd4};
    vec[5]  = '{1, 1, 0, 0, 0, 0, 4'd5, 8'hB0, 0,   0,  1,  4'd4, 8'hA0, 0, 0, 8'd5};
    vec[6]  = '{1, 1, 1, 0, 1, 0, 4'd6, 8'hC0, 0,   0,  1,  4'd4, 8'hA0, 0, 0, 8'd5};
    vec[7]  = '{1, 1, 1, 0, 1, 0, 4'd6, 8'hC0, 0,   0,  1,  4'd4, 8'hA0, 0, 0, 8'd5};
    vec[8]  = '{1, 1, 1, 0, 1, 0, 4'd6, 8'hC0, 1,   1,  1,  4'd5, 8'hB0, 0, 0, 8'd5};
    vec[9]  = '{0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0,   1,  1,  4'd5, 8'hB0, 0, 0, 8'd5};
    vec[10] = '{1, 0, 1, 0, 1, 0, 4'd0, 8'h01, 0,   1,  1,  4'd5, 8'hB0, 1, 0, 8'd6};
    vec[11] = '{1, 1, 0, 1, 0, 1, 4'd7, 8'h7F, 0,   0,  1,  4'd5, 8'hB0, 1, 1, 8'd7};
    vec[12] = '{1, 1, 1, 1, 0, 0, 4'd8, 8'h99, 0,   0,  1,  4'd5, 8'hB0, 1, 1, 8'd7};
    vec[13] = '{0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 1,   1,  1,  4'd7, 8'h7F, 1, 1, 8'd7};
    vec[14] = '{0, 0, 0, 0, 0, 0, 4'd0, 8'h00, 1,   1,  0,  4'd0, 8'h00, 1, 1, 8'd7};
    vec[15] = '{1, 0, 1, 0, 0, 0, 4'd0, 8'h00, 0,   1,  0,  4'd0, 8'h00, 0, 1, 8'd8};

    // Reset values, IN_READY is high while still in reset.
    RESET_N = 1'b0;
    driveInputs(0, 0, 0, 0, 0, 0, 4'd0, 8'd0, 0);
    stepCycle();
    checkOutput("reset IN_READY", {7'd0, bus.IN_READY}, 8'd1);
    checkOutput("reset RF_VALID", {7'd0, bus.RF_VALID}, 8'd0);
    checkOutput("reset RF_ADDR", {4'd0, bus.RF_ADDR}, 8'd0);
    checkOutput("reset RF_DATA", bus.RF_DATA, 8'd0);
    checkOutput("reset FLAG_Q", {7'd0, bus.FLAG_Q}, 8'd0);
    checkOutput("reset OVERFLOW_Q", {7'd0, bus.OVERFLOW_Q}, 8'd0);
    checkOutput("reset COMMIT_COUNT", bus.COMMIT_COUNT, 8'd0);
    stepCycle();
    RESET_N = 1'b1;

    prevReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i, prevReady);
      prevReady = vec[i].expInReady;
    end

    // Fill the queue and set status, then reset asynchronously in the middle of a cycle.
    driveInputs(1, 1, 1, 1, 1, 1, 4'd9, 8'hD1, 0);
    stepCycle();
    driveInputs(1, 1, 0, 0, 0, 0, 4'd10, 8'hD2, 0);
    stepCycle();
    driveInputs(0, 0, 0, 0, 0, 0, 4'd0, 8'd0, 0);
    checkOutput("prefill IN_READY", {7'd0, bus.IN_READY}, 8'd0);
    checkOutput("prefill COMMIT_COUNT", bus.COMMIT_COUNT, 8'd10);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("async reset RF_VALID", {7'd0, bus.RF_VALID}, 8'd0);
    checkOutput("async reset IN_READY", {7'd0, bus.IN_READY}, 8'd1);
    checkOutput("async reset FLAG_Q", {7'd0, bus.FLAG_Q}, 8'd0);
    checkOutput("async reset OVERFLOW_Q", {7'd0, bus.OVERFLOW_Q}, 8'd0);
    checkOutput("async reset COMMIT_COUNT", bus.COMMIT_COUNT, 8'd0);
    checkOutput("async reset RF_DATA", bus.RF_DATA, 8'd0);
    stepCycle();
    RESET_N = 1'b1;
    bus.RF_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput($sformatf("post-reset RF_VALID c%0d", i), {7'd0, bus.RF_VALID}, 8'd0);
    end

    // Sustained push+pop in ONE: each new entry replaces the head, oldest-first order holds.
    driveInputs(1, 1, 0, 0, 0, 0, 4'd8, 8'h50, 0);
    stepCycle();
    prevData = 8'h50;
    for (int i = 0; i < 10; i++) begin
      driveInputs(1, 1, 0, 0, 0, 0, 4'(i), 8'(8'h60 + i), 1);
      #1;
      checkOutput($sformatf("stream%0d head before pop", i), bus.RF_DATA, prevData);
      @(posedge CLK);
      #1;
      checkOutput($sformatf("stream%0d RF_VALID", i), {7'd0, bus.RF_VALID}, 8'd1);
      checkOutput($sformatf("stream%0d IN_READY", i), {7'd0, bus.IN_READY}, 8'd1);
      checkOutput($sformatf("stream%0d RF_ADDR", i), {4'd0, bus.RF_ADDR}, 8'(i));
      checkOutput($sformatf("stream%0d RF_DATA", i), bus.RF_DATA, 8'(8'h60 + i));
      prevData = 8'(8'h60 + i);
    end
    driveInputs(0, 0, 0, 0, 0, 0, 4'd0, 8'd0, 1);
    stepCycle();
    checkOutput("stream drain RF_VALID", {7'd0, bus.RF_VALID}, 8'd0);
    checkOutput("stream COMMIT_COUNT", bus.COMMIT_COUNT, 8'd11);

    // Counter wrap after 256 accepts that do not touch the queue.
    doReset();
    driveInputs(1, 0, 0, 0, 0, 0, 4'd0, 8'd0, 0);
    for (int i = 0; i < 255; i++) begin
      stepCycle();
    end
    checkOutput("count at 255", bus.COMMIT_COUNT, 8'd255);
    stepCycle();
    checkOutput("count wrap", bus.COMMIT_COUNT, 8'd0);
    checkOutput("wrap queue untouched", {7'd0, bus.RF_VALID}, 8'd0);
    driveInputs(0, 0, 0, 0, 0, 0, 4'd0, 8'd0, 0);
    stepCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_commit.md
# alu_commit

Commit stage directly downstream of the combinational ALU. It captures each accepted ALU result together with its flag and overflow outputs. It holds the architectural FLAG and OVERFLOW registers, which feed straight back to the ALU's FLAG_IN/OVERFLOW_IN. Register-file writes are queued in a 2-entry buffer so the shared write port (also used by load data) can stall without dropping results.

## Interface
Parameters:
- DW, 8: data width of ALU result and write data.
- AW, 4: register-file address width.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET_N  in  1  reset, asynchronous and active-low.
- IN_VALID  in  1  ALU result valid this cycle.
- IN_READY  out  1  stage can accept; IN_VALID && IN_READY = accept.
- ALU_RESULT  in  DW  ALU OUT.
- ALU_FLAG  in  1  ALU FLAG_OUT.
- ALU_OVERFLOW  in  1  ALU OVERFLOW_OUT.
- FLAG_WRITE  in  1  update FLAG register on accept (CEQ/CLT).
- OVERFLOW_WRITE  in  1  update OVERFLOW register on accept (ALU overflow_write).
- REG_WRITE  in  1  accepted result also writes the register file.
- WR_ADDR  in  AW  destination register.
- FLAG_Q  out  1  architectural flag, to ALU FLAG_IN.
- OVERFLOW_Q  out  1  architectural overflow, to ALU OVERFLOW_IN.
- RF_VALID  out  1  head-of-queue write pending.
- RF_READY  in  1  register-file port takes the write this cycle.
- RF_ADDR  out  AW  head entry address.
- RF_DATA  out  DW  head entry data.
- COMMIT_COUNT  out  8  accepted-transaction counter.

## Operation
- Queue: 2 entries {WR_ADDR, ALU_RESULT}, with FIFO order and states EMPTY, ONE, FULL.
- IN_READY = (state != FULL). It depends only on state and has no combinational path from RF_READY.
- Push = accept && REG_WRITE. Pop = RF_VALID && RF_READY.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE, with the new entry replacing the head.
  - FULL: pop -> ONE. Push is impossible because IN_READY=0.
- RF_VALID = (state != EMPTY). RF_ADDR/RF_DATA always show the oldest entry. They stay stable while RF_VALID && !RF_READY.
- Accept with REG_WRITE=0 does not touch the queue. It is still refused when FULL.
- FLAG register: on accept with FLAG_WRITE=1, FLAG_Q <= ALU_FLAG. Otherwise it holds.
- OVERFLOW register: on accept with OVERFLOW_WRITE=1, OVERFLOW_Q <= ALU_OVERFLOW. Otherwise it holds.
- Status updates happen at accept, not at queue drain, so the next ALU operation sees them regardless of RF stalls.
- COMMIT_COUNT increments by 1 on every accept. It wraps 255 -> 0.
- IN_VALID=0: no state change except pops.

## Timing
- Reset (RESET_N=0, asynchronous):
  - State EMPTY, FLAG_Q=0, OVERFLOW_Q=0, COMMIT_COUNT=0.
  - RF_VALID=0, RF_ADDR=0, RF_DATA=0.
  - IN_READY=1 once in EMPTY, including during reset.
- Reset mid-operation: queued writes are discarded. No RF_VALID pulse appears after reset deasserts.
- Latency: accept in cycle N -> RF_VALID/RF_ADDR/RF_DATA present from cycle N+1. FLAG_Q/OVERFLOW_Q are updated from cycle N+1.
- Throughput: 1 accept/cycle while RF_READY=1 every cycle. State stays in ONE.
- RF_READY held low: two REG_WRITE accepts fill the queue, and IN_READY=0 from the next cycle.
- Pop and push in the same cycle when FULL: only the pop occurs. State goes to ONE and IN_READY=1 next cycle.
- Inputs are sampled only when IN_VALID && IN_READY. Values present while IN_READY=0 are ignored.

## Test plan
- Reset: drive RESET_N=0 mid-stream with 2 entries queued -> immediately RF_VALID=0, FLAG_Q=0, OVERFLOW_Q=0, COMMIT_COUNT=0, IN_READY=1; after release no stale write is presented.
- Streaming: RF_READY=1; accept 0x11@r1, 0x22@r2, 0x33@r3 back-to-back -> RF writes appear on cycles N+1..N+3 in order; COMMIT_COUNT=3.
- Backpressure: RF_READY=0; accept 0xA0@r4, 0xB0@r5 -> IN_READY=0 next cycle and a third IN_VALID is ignored. Raise RF_READY for 1 cycle -> r4/0xA0 retires, IN_READY=1. Data remains stable throughout the stall.
- Status: accept CEQ result with FLAG_WRITE=1, ALU_FLAG=1, REG_WRITE=0 -> FLAG_Q=1 next cycle with queue untouched. ADD with ALU_OVERFLOW=1, OVERFLOW_WRITE=1 while RF stalled -> OVERFLOW_Q=1 next cycle.
- Refusal: queue FULL; IN_VALID=1 with FLAG_WRITE=1, ALU_FLAG=1 -> FLAG_Q unchanged and COMMIT_COUNT unchanged.
- Counter wrap: 256 accepts -> COMMIT_COUNT returns to 0. Push+pop in ONE state for 10 cycles -> state stays ONE and data order is preserved.
